// File: rtl/led_pulse_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
package led_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    // Larger of two integers, used to size the shared blink/gap timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle events into visible LED blinks: ON_CYCLES high,
// then at least OFF_CYCLES low. Events that arrive while a blink or its gap
// is running are queued in a saturating pending counter.
module led_pulse_stretcher
    import led_pulse_pkg::*;
#(
    parameter  int ON_CYCLES  = 20,
    parameter  int OFF_CYCLES = 20,
    parameter  int PEND_MAX   = 7,
    localparam int CNT_BITS   = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 32'sd1),
    localparam int PEND_BITS  = $clog2(PEND_MAX + 32'sd1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_event,
    output logic                 o_led,
    output logic                 o_busy,
    output logic [PEND_BITS-1:0] o_pending,
    output logic                 o_overflow
);

    localparam logic [CNT_BITS-1:0]  ON_LAST   = CNT_BITS'(ON_CYCLES - 32'sd1);
    localparam logic [CNT_BITS-1:0]  OFF_LAST  = CNT_BITS'(OFF_CYCLES - 32'sd1);
    localparam logic [PEND_BITS-1:0] PEND_FULL = PEND_BITS'(PEND_MAX);

    if (ON_CYCLES < 32'sd1 || OFF_CYCLES < 32'sd1 || PEND_MAX < 32'sd1) begin : g_param_check
        $error("led_pulse_stretcher: ON_CYCLES, OFF_CYCLES and PEND_MAX must all be >= 1");
    end

    led_state_t           state_r;
    led_state_t           state_nxt_s;
    logic [CNT_BITS-1:0]  timer_r;
    logic [CNT_BITS-1:0]  timer_nxt_s;
    logic [PEND_BITS-1:0] pend_r;
    logic [PEND_BITS-1:0] pend_nxt_s;
    logic                 ovf_r;
    logic                 ovf_nxt_s;
    logic                 led_r;
    logic                 busy_r;
    logic                 start_s;

    // Next-state, timer and pending-queue logic; a start consumes either the
    // live event or (without one) a queued entry.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        pend_nxt_s  = pend_r;
        ovf_nxt_s   = ovf_r;
        start_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (i_event || (pend_r != {PEND_BITS{1'b0}})) begin
                    start_s = 1'b1;
                end else begin
                    timer_nxt_s = {CNT_BITS{1'b0}};
                end
            end
            ON: begin
                if (timer_r == ON_LAST) begin
                    state_nxt_s = GAP;
                    timer_nxt_s = {CNT_BITS{1'b0}};
                end else begin
                    timer_nxt_s = timer_r + CNT_BITS'(1);
                end
            end
            GAP: begin
                if (timer_r == OFF_LAST) begin
                    if (i_event || (pend_r != {PEND_BITS{1'b0}})) begin
                        start_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        timer_nxt_s = {CNT_BITS{1'b0}};
                    end
                end else begin
                    timer_nxt_s = timer_r + CNT_BITS'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                timer_nxt_s = {CNT_BITS{1'b0}};
            end
        endcase

        if (start_s) begin
            state_nxt_s = ON;
            timer_nxt_s = {CNT_BITS{1'b0}};
            if (!i_event) begin
                pend_nxt_s = pend_r - PEND_BITS'(1);
            end else begin
                pend_nxt_s = pend_r;
            end
        end else if (i_event) begin
            if (pend_r == PEND_FULL) begin
                ovf_nxt_s = 1'b1;
            end else begin
                pend_nxt_s = pend_r + PEND_BITS'(1);
            end
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // State, counters and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= {CNT_BITS{1'b0}};
            pend_r  <= {PEND_BITS{1'b0}};
            ovf_r   <= 1'b0;
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            pend_r  <= pend_nxt_s;
            ovf_r   <= ovf_nxt_s;
            led_r   <= (state_nxt_s == ON);
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign o_led      = led_r;
    assign o_busy     = busy_r;
    assign o_pending  = pend_r;
    assign o_overflow = ovf_r;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher. Two instances (PEND_MAX=2 and 7)
// see the same stimulus; an age-based blink model is compared every cycle,
// and hand-computed literals pin the key timing points of each scenario.
module tb_led_pulse_stretcher;

    localparam int ON  = 4;
    localparam int OFF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_event = 1'b0;
    logic       led_a, busy_a, ovf_a;
    logic [1:0] pend_a;
    logic       led_b, busy_b, ovf_b;
    logic [2:0] pend_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // Model state per instance: age = cycles since current blink began (-1 idle).
    int pmax [2] = '{2, 7};
    int m_age [2];
    int m_pend [2];
    int m_ovf [2];

    led_pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_MAX(2)) dut_a (
        .clk(clk), .rst(rst), .i_event(i_event),
        .o_led(led_a), .o_busy(busy_a), .o_pending(pend_a), .o_overflow(ovf_a)
    );

    led_pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_MAX(7)) dut_b (
        .clk(clk), .rst(rst), .i_event(i_event),
        .o_led(led_b), .o_busy(busy_b), .o_pending(pend_b), .o_overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a blink occupies ON+OFF cycles; a new one may begin
    // only when idle or on the final gap cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_age[k]  = -1;
                m_pend[k] = 0;
                m_ovf[k]  = 0;
            end else if (m_age[k] < 0 || m_age[k] == ON + OFF - 1) begin
                if (i_event) begin
                    m_age[k] = 0;
                end else if (m_pend[k] > 0) begin
                    m_age[k]  = 0;
                    m_pend[k] = m_pend[k] - 1;
                end else begin
                    m_age[k] = -1;
                end
            end else begin
                m_age[k] = m_age[k] + 1;
                if (i_event) begin
                    if (m_pend[k] == pmax[k]) m_ovf[k] = 1;
                    else m_pend[k] = m_pend[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("model led_a",  int'(led_a),  int'(m_age[0] >= 0 && m_age[0] < ON));
            chk("model busy_a", int'(busy_a), int'(m_age[0] >= 0));
            chk("model pend_a", int'(pend_a), m_pend[0]);
            chk("model ovf_a",  int'(ovf_a),  m_ovf[0]);
            chk("model led_b",  int'(led_b),  int'(m_age[1] >= 0 && m_age[1] < ON));
            chk("model busy_b", int'(busy_b), int'(m_age[1] >= 0));
            chk("model pend_b", int'(pend_b), m_pend[1]);
            chk("model ovf_b",  int'(ovf_b),  m_ovf[1]);
        end
    end

    function automatic bit ev_of(input int t, input int c);
        case (t)
            1: return c == 10;
            2: return c >= 10 && c <= 12;
            3: return c >= 10 && c <= 13;
            4: return c == 10 || c == 17;
            5: return c == 10 || c == 11;
            6: return c >= 10 && c <= 29;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        int len, r, blinks_a, blinks_b, busy_low;
        bit prev_a, prev_b;
        for (int t = 1; t <= 6; t++) begin
            len = (t == 6) ? 90 : 40;
            blinks_a = 0; blinks_b = 0; busy_low = 0;
            prev_a = 1'b0; prev_b = 1'b0;
            for (int c = 0; c < len; c++) begin
                rst     = (c < 2) || (t == 5 && c == 12);
                i_event = ev_of(t, c);
                @(posedge clk);
                #1;
                check_en = 1'b1;
                r = c + 1;
                if (r >= 3) begin
                    if (led_a && !prev_a) blinks_a++;
                    if (led_b && !prev_b) blinks_b++;
                end
                prev_a = led_a;
                prev_b = led_b;
                case (t)
                    1: begin
                        if (r == 1)  chk("t1 reset led", int'(led_a), 0);
                        if (r == 1)  chk("t1 reset pend", int'(pend_a), 0);
                        if (r == 10) chk("t1 led c10", int'(led_a), 0);
                        if (r == 11) chk("t1 led c11", int'(led_a), 1);
                        if (r == 14) chk("t1 led c14", int'(led_a), 1);
                        if (r == 15) chk("t1 led c15", int'(led_a), 0);
                        if (r == 17) chk("t1 busy c17", int'(busy_a), 1);
                        if (r == 18) chk("t1 busy c18", int'(busy_a), 0);
                    end
                    2: begin
                        if (r == 13) chk("t2 pend c13", int'(pend_a), 2);
                        if (r == 17) chk("t2 led c17", int'(led_a), 0);
                        if (r == 18) chk("t2 led c18", int'(led_a), 1);
                        if (r == 25) chk("t2 led c25", int'(led_a), 1);
                        if (r == 28) chk("t2 led c28", int'(led_a), 1);
                        if (r == 29) chk("t2 led c29", int'(led_a), 0);
                        if (r == 30) chk("t2 ovf c30", int'(ovf_a), 0);
                    end
                    3: begin
                        if (r == 13) chk("t3 ovf c13", int'(ovf_a), 0);
                        if (r == 14) chk("t3 ovf c14", int'(ovf_a), 1);
                        if (r == 14) chk("t3 pend c14", int'(pend_a), 2);
                    end
                    4: begin
                        if (r == 18) chk("t4 led c18", int'(led_a), 1);
                        if (r >= 11 && r <= 24 && !busy_a) busy_low++;
                    end
                    5: begin
                        if (r == 13) chk("t5 led c13", int'(led_a), 0);
                        if (r == 13) chk("t5 pend c13", int'(pend_a), 0);
                        if (r == 13) chk("t5 busy c13", int'(busy_a), 0);
                    end
                    6: begin
                        if (r == 30) chk("t6 pend c30", int'(pend_b), 7);
                        if (r == 30) chk("t6 ovf c30", int'(ovf_b), 1);
                    end
                    default: ;
                endcase
            end
            case (t)
                2: chk("t2 blinks", blinks_a, 3);
                3: chk("t3 blinks", blinks_a, 3);
                4: begin
                    chk("t4 busy gaps", busy_low, 0);
                    chk("t4 blinks", blinks_a, 2);
                end
                5: chk("t5 blinks", blinks_a, 1);
                6: begin
                    // Starts at 11, 18 and 25 take the live event (it lands on
                    // the last gap cycle), then seven queued entries drain.
                    chk("t6 blinks", blinks_b, 10);
                    chk("t6 busy end", int'(busy_b), 0);
                    chk("t6 pend end", int'(pend_b), 0);
                end
                default: ;
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
